// File: rtl/calc_operand_sequencer_v.sv
// Serial a/b/c nibble loader, settle timer and result register for the 7a-3b+6c calc.
// Optional CALC_SEQ_SATURATE_EN clamps overflowing results to 8'h7F.
module calc_operand_sequencer_v #(
  parameter int unsigned EVAL_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_nib_valid,
  input  logic [3:0] i_nib,
  output logic       o_nib_ready,
  output logic [3:0] o_au,
  output logic [3:0] o_bu,
  output logic [3:0] o_cu,
  input  logic [7:0] i_fu,
  output logic       o_res_valid,
  output logic [7:0] o_res,
  input  logic       i_res_ready,
  output logic       o_ovf
);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_C,
    EVAL,
    RESULT
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EVAL_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       nib_xfer;
  logic       res_xfer;
  logic       capture;
  logic [9:0] lhs;
  logic [9:0] rhs;
  logic       ovf;
  logic [7:0] res_nx;

  assign o_nib_ready = (state == LOAD_A) ||
                       (state == LOAD_B) ||
                       (state == LOAD_C);
  assign nib_xfer = i_nib_valid & o_nib_ready;
  assign res_xfer = o_res_valid & i_res_ready;
  assign capture  = (state == EVAL) && (cnt == 4'd0);

  // Overflow test kept unsigned: 7a+6c-3b > 127
  assign lhs = 10'd7 * {6'd0, o_au} + 10'd6 * {6'd0, o_cu};
  assign rhs = 10'd127 + 10'd3 * {6'd0, o_bu};
  assign ovf = lhs > rhs;

`ifdef CALC_SEQ_SATURATE_EN
  assign res_nx = ovf ? 8'h7F : i_fu;
`else
  assign res_nx = i_fu;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= LOAD_A;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD_A: if (nib_xfer) state_nx = LOAD_B;
      LOAD_B: if (nib_xfer) state_nx = LOAD_C;
      LOAD_C: if (nib_xfer) state_nx = EVAL;
      EVAL:   if (capture) state_nx = RESULT;
      RESULT: if (res_xfer) state_nx = LOAD_A;
      default: state_nx = LOAD_A;
    endcase
    if (i_clear) state_nx = LOAD_A;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_au        <= 4'd0;
      o_bu        <= 4'd0;
      o_cu        <= 4'd0;
      o_res       <= 8'd0;
      o_res_valid <= 1'b0;
      o_ovf       <= 1'b0;
      cnt         <= 4'd0;
    end else if (i_clear) begin
      o_res_valid <= 1'b0;
      o_ovf       <= 1'b0;
      cnt         <= 4'd0;
    end else begin
      if (nib_xfer && state == LOAD_A) o_au <= i_nib;
      if (nib_xfer && state == LOAD_B) o_bu <= i_nib;
      if (nib_xfer && state == LOAD_C) begin
        o_cu <= i_nib;
        cnt  <= CNT_INIT;
      end
      if (state == EVAL && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (capture) begin
        o_res       <= res_nx;
        o_ovf       <= ovf;
        o_res_valid <= 1'b1;
      end
      if (res_xfer) o_res_valid <= 1'b0;
    end
  end

endmodule
